div_iter_param: RTL
===================

Name: div_iter_param

Overview:
- Parametrised multi-cycle iterative integer divider, the successor to the fixed 32-bit single-bit-per-cycle divider in the EX stage.
- Adds configurable operand width and radix (bits retired per cycle).
- Returns quotient and remainder on separate ports, with an explicit divide-by-zero flag and a busy indication.
- Sits beside the ALU and is driven by the EX-stage stall logic through a start/ready/annul handshake.

Parameters:
WIDTH, 32, operand/quotient/remainder width; even, >= 4
STEPS, 1, quotient bits retired per cycle; 1 or 2; WIDTH % STEPS == 0

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
signed_div_i  in  1  1 = two's-complement operands, 0 = unsigned
opdata1_i  in  WIDTH  dividend
opdata2_i  in  WIDTH  divisor
start_i  in  1  request; held high until result consumed
annul_i  in  1  cancel in-flight operation (pipeline flush)
quotient_o  out  WIDTH  registered quotient
remainder_o  out  WIDTH  registered remainder
div_zero_o  out  1  result produced by zero divisor
ready_o  out  1  result valid
busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst low, async): state = IDLE; quotient_o, remainder_o, div_zero_o, ready_o, busy_o all 0. Reset mid-operation discards all work.
- States: IDLE, BUSY, FIX, DONE.
- IDLE:
  - If start_i=1 and annul_i=0, operands are sampled on this edge.
  - Divisor == 0 → DONE directly (ready_o at edge 1):
    - quotient_o = all ones.
    - remainder_o = opdata1_i unmodified.
    - div_zero_o = 1.
  - Otherwise → BUSY:
    - Store |op1| and |op2|; absolute value is taken only when signed_div_i=1 and the MSB is set.
    - Store the sign flags neg_q = s1^s2 and neg_r = s1.
    - Iteration counter = 0.
- BUSY:
  - One restoring-division step per STEPS bit.
  - Each step shifts the partial remainder left 1, shifts in the next dividend bit, and trial-subtracts the divisor using a WIDTH+1-bit subtract.
  - Borrow clear → partial remainder = difference, quotient bit 1.
  - Borrow set → quotient bit 0.
  - STEPS=2 chains two steps combinationally per cycle.
  - Counter increments by 1 per cycle. After WIDTH/STEPS cycles → FIX.
- FIX (1 cycle):
  - Negate the quotient if neg_q.
  - Negate the remainder if neg_r and the remainder != 0.
  - Load quotient_o/remainder_o; div_zero_o = 0 → DONE.
- Latency (non-zero divisor): ready_o rises after edge WIDTH/STEPS + 2, counting the start-sampling edge as edge 1. That is 34 for 32/1 and 18 for 32/2.
- DONE:
  - ready_o = 1; outputs are held stable.
  - When start_i=0 is sampled: → IDLE, and ready_o, quotient_o, remainder_o, div_zero_o are cleared to 0 on that edge.
  - start_i held high keeps DONE indefinitely. A new operation requires start_i to drop for at least one cycle.
- annul_i=1 in BUSY, FIX or DONE: → IDLE on the next edge, all outputs cleared, no ready_o pulse. annul_i has priority over completion on the same edge.
- annul_i=1 in IDLE blocks the start.
- Operand changes while not IDLE are ignored; all sign decisions use the latched flags.
- Signed overflow (MIN / -1): quotient = MIN, remainder = 0. This falls out of the unsigned core plus negation with no special case.
- Remainder sign follows the dividend; |remainder| < |divisor|.
- busy_o = (state != IDLE), registered along with the state.

Test Plan:
1. Unsigned, WIDTH=32, STEPS=1: 100 / 7 → at edge 34 ready_o=1, quotient_o=14, remainder_o=2, div_zero_o=0. Then drop start_i → next edge all outputs 0, busy_o=0.
2. Signed:
   - -100 / 7 → quotient_o=0xFFFFFFF2, remainder_o=0xFFFFFFFE.
   - 100 / -7 → quotient_o=0xFFFFFFF2, remainder_o=2.
   - 0x80000000 / 0xFFFFFFFF → quotient_o=0x80000000, remainder_o=0.
3. Divide by zero: 5 / 0 with signed_div_i=1 → ready_o at edge 1, quotient_o=0xFFFFFFFF, remainder_o=5, div_zero_o=1, busy_o=1 until start_i drops.
4. Annul: start 0xFFFFFFFF / 3 unsigned, assert annul_i one cycle at edge 10 → IDLE next edge, ready_o never rises. An immediate restart with 9 / 3 → quotient 3, remainder 0 at edge 34.
5. STEPS=2, WIDTH=32: 0xFFFFFFFF / 0x10 unsigned → ready at edge 18, quotient_o=0x0FFFFFFF, remainder_o=0xF.
   - WIDTH=8, STEPS=1 signed -128 / 3 → quotient_o=0xD6, remainder_o=0xFE at edge 10.
6. Async reset pulse (rst low) mid-BUSY at edge 15 → outputs 0 immediately without a clock. After release, 1 / 1 completes normally with quotient 1, remainder 0.

Source files
------------

// File: rtl/div_iter_param.sv
// Iterative restoring divider, WIDTH-bit operands, STEPS quotient bits per cycle.
// Signed mode divides magnitudes, then fixes signs in a single cycle.
module div_iter_param #(
  parameter int WIDTH = 32,
  parameter int STEPS = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             signed_div_i,
  input  logic [WIDTH-1:0] opdata1_i,
  input  logic [WIDTH-1:0] opdata2_i,
  input  logic             start_i,
  input  logic             annul_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o,
  output logic             div_zero_o,
  output logic             ready_o,
  output logic             busy_o
);

  localparam int ITER = WIDTH / STEPS;
  localparam int CW   = $clog2(ITER + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    FIX,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             neg_q_q, neg_q_d;
  logic             neg_r_q, neg_r_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;

  logic             s1, s2;
  logic [WIDTH-1:0] step_r, step_q;

  // quo holds the unshifted dividend bits on top, quotient bits on the bottom
  function automatic logic [2*WIDTH-1:0] div_step(
    input logic [WIDTH-1:0] r,
    input logic [WIDTH-1:0] q,
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH:0]   sh;
    logic [WIDTH+1:0] df;
    sh = {r, q[WIDTH-1]};
    df = {1'b0, sh} - {2'b00, d};
    if (df[WIDTH+1])
      return {sh[WIDTH-1:0], q[WIDTH-2:0], 1'b0};
    else
      return {df[WIDTH-1:0], q[WIDTH-2:0], 1'b1};
  endfunction

  assign s1 = signed_div_i & opdata1_i[WIDTH-1];
  assign s2 = signed_div_i & opdata2_i[WIDTH-1];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    neg_q_d     = neg_q_q;
    neg_r_d     = neg_r_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;
    ready_d     = ready_q;
    step_r      = rem_q;
    step_q      = quo_q;

    unique case (state_q)
      IDLE: begin
        if (start_i && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = opdata1_i;
            div_zero_d  = 1'b1;
            ready_d     = 1'b1;
          end else begin
            state_d = BUSY;
            quo_d   = s1 ? -opdata1_i : opdata1_i;
            dvs_d   = s2 ? -opdata2_i : opdata2_i;
            rem_d   = '0;
            cnt_d   = '0;
            neg_q_d = s1 ^ s2;
            neg_r_d = s1;
          end
        end
      end
      BUSY: begin
        for (int i = 0; i < STEPS; i++)
          {step_r, step_q} = div_step(step_r, step_q, dvs_q);
        rem_d = step_r;
        quo_d = step_q;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(ITER - 1))
          state_d = FIX;
      end
      FIX: begin
        quotient_d  = neg_q_q ? -quo_q : quo_q;
        remainder_d = (neg_r_q && rem_q != '0) ? -rem_q : rem_q;
        div_zero_d  = 1'b0;
        ready_d     = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (!start_i) begin
          state_d     = IDLE;
          quotient_d  = '0;
          remainder_d = '0;
          div_zero_d  = 1'b0;
          ready_d     = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    // flush wins over completion
    if (annul_i && state_q != IDLE) begin
      state_d     = IDLE;
      quotient_d  = '0;
      remainder_d = '0;
      div_zero_d  = 1'b0;
      ready_d     = 1'b0;
    end

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
      ready_q     <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      neg_q_q     <= neg_q_d;
      neg_r_q     <= neg_r_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
      ready_q     <= ready_d;
      busy_q      <= busy_d;
    end
  end

  assign quotient_o  = quotient_q;
  assign remainder_o = remainder_q;
  assign div_zero_o  = div_zero_q;
  assign ready_o     = ready_q;
  assign busy_o      = busy_q;

endmodule
